// File: rtl/instruction_loader.sv
// instruction_loader: receives a serial byte stream, assembles 32-bit
// instruction words MSB first, and writes them to consecutive word
// addresses starting at base_addr. The write address wraps modulo 2^ADDR_W.
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, the loader
// keeps a running XOR of all written words and compares it with one trailing
// 32-bit word, setting checksum_err on a mismatch. When it is undefined,
// checksum_err is tied to 0.
module instruction_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_len,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              checksum_err
);

    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, CHECK, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] idx_inc;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       csum_q, csum_d;
    logic              cerr_q, cerr_d;
`endif

    assign idx_inc = idx_q + ADDR_W'(1);

    // State and datapath registers; reset aborts any session and drops a partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
            cerr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            cerr_q     <= cerr_d;
`endif
        end
    end

    // Next-state logic: session start, byte assembly, word write, trailer check.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        cerr_d     = cerr_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    base_d     = base_addr;
                    len_d      = word_len;
                    idx_d      = '0;
                    byte_cnt_d = '0;
                    word_d     = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = '0;
                    cerr_d     = 1'b0;
`endif
                    // An empty session completes immediately without touching memory.
                    state_d    = (word_len == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (byte_valid) begin
                    word_d     = {word_q[23:0], byte_in};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                idx_d = idx_inc;
`ifdef LOADER_CHECKSUM_EN
                csum_d = csum_q ^ word_q;
                state_d = (idx_inc == len_q) ? CHECK : COLLECT;
`else
                state_d = (idx_inc == len_q) ? DONE : COLLECT;
`endif
            end
            CHECK: begin
                if (byte_valid) begin
                    word_d     = {word_q[23:0], byte_in};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
`ifdef LOADER_CHECKSUM_EN
                        cerr_d = ({word_q[23:0], byte_in} != csum_q);
`endif
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_ready = (state_q == COLLECT) || (state_q == CHECK);
    assign mem_we     = (state_q == WRITE);
    assign mem_addr   = (state_q == WRITE) ? (base_q + idx_q) : '0;
    assign mem_wdata  = (state_q == WRITE) ? word_q : '0;
    assign busy       = (state_q == COLLECT) || (state_q == WRITE) || (state_q == CHECK);
    assign done       = (state_q == DONE);
`ifdef LOADER_CHECKSUM_EN
    assign checksum_err = cerr_q;
`else
    assign checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// Directed testbench for instruction_loader with hand-computed expectations.
module tb_instruction_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] word_len;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              checksum_err;

    int n_vec = 0;
    int n_err = 0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];

    instruction_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_len(word_len), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .checksum_err(checksum_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Record every write strobe; byte_ready must be low while writing.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            check_eq("ready_in_write", {31'd0, byte_ready}, 32'd0);
        end
    end

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
        start = 1'b1; base_addr = b; word_len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        byte_in = b; byte_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (byte_ready) begin
                @(negedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_eq("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        send_byte(t[31:24]); send_byte(t[23:16]); send_byte(t[15:8]); send_byte(t[7:0]);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 50; i++) begin
            if (done) break;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        check_eq("done", {31'd0, done}, 32'd1);
        check_eq("busy_after", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq(tag, {byte_ready, mem_we, busy, done, checksum_err, mem_addr, mem_wdata[15:0]}, 32'd0);
        check_eq({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; word_len = '0;
        byte_in = '0; byte_valid = 1'b0;
        #1;
        check_outputs_zero("reset_state");
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Two-word program at base 0
        wr_addr.delete(); wr_data.delete();
        do_start(10'h000, 10'd2);
        check_eq("busy_collect", {31'd0, busy}, 32'd1);
        send_word(32'h20080005);
        send_word(32'h8C090000);
        wait_done();
        check_eq("t1_nwr", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check_eq("t1_a0", 32'(wr_addr[0]), 32'h000);
            check_eq("t1_d0", wr_data[0], 32'h20080005);
            check_eq("t1_a1", 32'(wr_addr[1]), 32'h001);
            check_eq("t1_d1", wr_data[1], 32'h8C090000);
        end
        check_eq("t1_cerr", {31'd0, checksum_err}, 32'd0);

        // Gapped byte_valid; a start pulse mid-session must be ignored
        wr_addr.delete(); wr_data.delete();
        do_start(10'h005, 10'd1);
        check_eq("t2_done_clr", {31'd0, done}, 32'd0);
        send_byte(8'h12); byte_valid = 1'b0;
        start = 1'b1; base_addr = 10'h099; word_len = 10'd3;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h34); byte_valid = 1'b0; @(negedge clk);
        send_byte(8'h56); byte_valid = 1'b0; @(negedge clk);
        send_byte(8'h78); byte_valid = 1'b0;
        wait_done();
        check_eq("t2_nwr", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check_eq("t2_a0", 32'(wr_addr[0]), 32'h005);
            check_eq("t2_d0", wr_data[0], 32'h12345678);
        end

        // Address wrap at the top of the word space
        wr_addr.delete(); wr_data.delete();
        do_start(10'h3FF, 10'd2);
        send_word(32'hAABBCCDD);
        send_word(32'h11223344);
        wait_done();
        check_eq("t3_nwr", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check_eq("t3_a0", 32'(wr_addr[0]), 32'h3FF);
            check_eq("t3_d0", wr_data[0], 32'hAABBCCDD);
            check_eq("t3_a1", 32'(wr_addr[1]), 32'h000);
            check_eq("t3_d1", wr_data[1], 32'h11223344);
        end

        // Reset after two bytes: immediate clear, no write, partial word dropped
        wr_addr.delete(); wr_data.delete();
        do_start(10'h010, 10'd1);
        send_byte(8'hCA); send_byte(8'hFE);
        byte_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_outputs_zero("t4_reset_now");
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        check_eq("t4_nwr_abort", wr_addr.size(), 0);
        do_start(10'h020, 10'd1);
        send_word(32'hDEADBEEF);
        wait_done();
        check_eq("t4_nwr", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check_eq("t4_a0", 32'(wr_addr[0]), 32'h020);
            check_eq("t4_d0", wr_data[0], 32'hDEADBEEF);
        end

        // Zero-length session from IDLE
        wr_addr.delete(); wr_data.delete();
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        check_eq("t5_done_pre", {31'd0, done}, 32'd0);
        do_start(10'h040, 10'd0);
        check_eq("t5_done", {31'd0, done}, 32'd1);
        check_eq("t5_busy", {31'd0, busy}, 32'd0);
        check_eq("t5_ready", {31'd0, byte_ready}, 32'd0);
        @(negedge clk);
        check_eq("t5_nwr", wr_addr.size(), 0);

`ifdef LOADER_CHECKSUM_EN
        // Matching trailer: 0x0000FFFF ^ 0xFFFF0000 = 0xFFFFFFFF
        do_start(10'h000, 10'd2);
        send_word(32'h0000FFFF);
        send_word(32'hFFFF0000);
        send_word(32'hFFFFFFFF);
        wait_done();
        check_eq("t6_cerr_ok", {31'd0, checksum_err}, 32'd0);
        // Mismatching trailer
        do_start(10'h000, 10'd2);
        send_word(32'h0000FFFF);
        send_word(32'hFFFF0000);
        send_word(32'h00000000);
        wait_done();
        check_eq("t6_cerr_bad", {31'd0, checksum_err}, 32'd1);
        // A new start clears the flag
        do_start(10'h000, 10'd0);
        check_eq("t6_cerr_clr", {31'd0, checksum_err}, 32'd0);
`else
        do_start(10'h000, 10'd1);
        send_word(32'h0000FFFF);
        wait_done();
        check_eq("t6_cerr_const", {31'd0, checksum_err}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
